// File: rtl/alu_seq_if.sv
// Request/response bundle between the issue stage, alu_seq and writeback.
// The master drives requests and accepts results; the slave is the ALU.
interface alu_seq_if #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
);
   logic               in_valid;
   logic               in_ready;
   logic [4:0]         opcode;
   logic [WIDTH-1:0]   op_a;
   logic [WIDTH-1:0]   op_b;
   logic [SHAMT_W-1:0] shamt;
   logic               out_valid;
   logic               out_ready;
   logic [WIDTH-1:0]   result;
   logic               flag_zero;
   logic               flag_dz;
   logic               flag_ill;

   modport master (
      output in_valid, opcode, op_a, op_b, shamt, out_ready,
      input  in_ready, out_valid, result, flag_zero, flag_dz, flag_ill
   );

   modport slave (
      input  in_valid, opcode, op_a, op_b, shamt, out_ready,
      output in_ready, out_valid, result, flag_zero, flag_dz, flag_ill
   );
endinterface

// File: rtl/alu_seq.sv
// Handshaked ALU that runs one operation at a time. Single-cycle ops finish on the accept edge.
// MUL (shift-add) and DIV/MOD (restoring) iterate for WIDTH cycles.
module alu_seq #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5
) (
   input  logic      clk,
   input  logic      rst,
   alu_seq_if.slave  bus
);

   localparam logic [4:0] OP_ADD  = 5'b00001;
   localparam logic [4:0] OP_SUB  = 5'b00010;
   localparam logic [4:0] OP_MUL  = 5'b00011;
   localparam logic [4:0] OP_DIV  = 5'b00100;
   localparam logic [4:0] OP_MOD  = 5'b00101;
   localparam logic [4:0] OP_MAX  = 5'b00110;
   localparam logic [4:0] OP_MIN  = 5'b00111;
   localparam logic [4:0] OP_NOT  = 5'b01000;
   localparam logic [4:0] OP_NAND = 5'b01001;
   localparam logic [4:0] OP_XNOR = 5'b01010;
   localparam logic [4:0] OP_SLL  = 5'b01011;
   localparam logic [4:0] OP_SRL  = 5'b01100;
   localparam logic [4:0] OP_SRA  = 5'b01101;

   localparam logic [SHAMT_W-1:0] LAST_ITER = SHAMT_W'(WIDTH - 1);
   localparam logic [WIDTH-1:0]   ALL_ZERO  = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0]   ALL_ONES  = {WIDTH{1'b1}};

   typedef enum logic [1:0] {
      S_IDLE = 2'b00,
      S_BUSY = 2'b01,
      S_DONE = 2'b10
   } state_t;

   function automatic logic is_iter(input logic [4:0] op);
      return (op == OP_MUL) || (op == OP_DIV) || (op == OP_MOD);
   endfunction

   function automatic logic is_legal(input logic [4:0] op);
      return (op >= OP_ADD) && (op <= OP_SRA);
   endfunction

   // DIV/MOD only reach this path with a zero divisor; illegal opcodes fall to zero.
   function automatic logic [WIDTH-1:0] single_op(
      input logic [4:0]         op,
      input logic [WIDTH-1:0]   a,
      input logic [WIDTH-1:0]   b,
      input logic [SHAMT_W-1:0] sh
   );
      logic signed [WIDTH-1:0] sa;
      logic [WIDTH-1:0]        r;
      sa = a;
      case (op)
         OP_ADD:  r = a + b;
         OP_SUB:  r = a - b;
         OP_DIV:  r = ALL_ONES;
         OP_MOD:  r = a;
         OP_MAX:  r = (a >= b) ? a : b;
         OP_MIN:  r = (a <= b) ? a : b;
         OP_NOT:  r = ~a;
         OP_NAND: r = ~(a & b);
         OP_XNOR: r = ~(a ^ b);
         OP_SLL:  r = a << sh;
         OP_SRL:  r = a >> sh;
         OP_SRA:  r = sa >>> sh;
         default: r = ALL_ZERO;
      endcase
      return r;
   endfunction

   state_t             state_r;
   state_t             state_nxt_s;
   logic [4:0]         op_r;
   logic [WIDTH-1:0]   acc_r;
   logic [WIDTH-1:0]   x_r;
   logic [WIDTH-1:0]   y_r;
   logic [SHAMT_W-1:0] cnt_r;
   logic [WIDTH-1:0]   result_r;
   logic               zero_r;
   logic               dz_r;
   logic               ill_r;

   logic               in_ready_s;
   logic               out_valid_s;
   logic               accept_s;
   logic               dz_in_s;
   logic               start_iter_s;
   logic               last_iter_s;
   logic [WIDTH-1:0]   single_res_s;
   logic [WIDTH:0]     shifted_s;
   logic [WIDTH-1:0]   diff_s;
   logic [WIDTH-1:0]   step_acc_s;
   logic [WIDTH-1:0]   step_x_s;
   logic [WIDTH-1:0]   step_y_s;
   logic [WIDTH-1:0]   iter_res_s;

   assign accept_s     = bus.in_valid && in_ready_s;
   assign dz_in_s      = ((bus.opcode == OP_DIV) || (bus.opcode == OP_MOD)) && (bus.op_b == ALL_ZERO);
   assign start_iter_s = is_iter(bus.opcode) && !dz_in_s;
   assign last_iter_s  = (cnt_r == LAST_ITER);
   assign single_res_s = single_op(bus.opcode, bus.op_a, bus.op_b, bus.shamt);

   assign bus.in_ready  = in_ready_s;
   assign bus.out_valid = out_valid_s;
   assign bus.result    = result_r;
   assign bus.flag_zero = zero_r;
   assign bus.flag_dz   = dz_r;
   assign bus.flag_ill  = ill_r;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         S_IDLE: begin
            if (accept_s) begin
               state_nxt_s = start_iter_s ? S_BUSY : S_DONE;
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_BUSY: begin
            if (last_iter_s) begin
               state_nxt_s = S_DONE;
            end else begin
               state_nxt_s = S_BUSY;
            end
         end
         S_DONE: begin
            if (bus.out_ready) begin
               state_nxt_s = S_IDLE;
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // Handshake outputs decoded from the state register.
   always_comb begin
      in_ready_s  = 1'b0;
      out_valid_s = 1'b0;
      case (state_r)
         S_IDLE:  in_ready_s  = 1'b1;
         S_DONE:  out_valid_s = 1'b1;
         default: begin
            in_ready_s  = 1'b0;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // One iteration step: MUL adds the shifted multiplicand, DIV/MOD shifts in one dividend bit.
   always_comb begin
      shifted_s  = {acc_r, x_r[WIDTH-1]};
      diff_s     = shifted_s[WIDTH-1:0] - y_r;
      step_acc_s = acc_r;
      step_x_s   = x_r;
      step_y_s   = y_r;
      if (op_r == OP_MUL) begin
         if (y_r[0]) begin
            step_acc_s = acc_r + x_r;
         end else begin
            step_acc_s = acc_r;
         end
         step_x_s = {x_r[WIDTH-2:0], 1'b0};
         step_y_s = {1'b0, y_r[WIDTH-1:1]};
      end else begin
         if (shifted_s >= {1'b0, y_r}) begin
            step_acc_s = diff_s;
            step_x_s   = {x_r[WIDTH-2:0], 1'b1};
         end else begin
            step_acc_s = shifted_s[WIDTH-1:0];
            step_x_s   = {x_r[WIDTH-2:0], 1'b0};
         end
      end
   end

   // Final iterative result: quotient sits in x_r, product and remainder in acc_r.
   always_comb begin
      case (op_r)
         OP_MUL:  iter_res_s = step_acc_s;
         OP_DIV:  iter_res_s = step_x_s;
         OP_MOD:  iter_res_s = step_acc_s;
         default: iter_res_s = ALL_ZERO;
      endcase
   end

   // Operand latch, iteration registers and held result/flags.
   always_ff @(posedge clk) begin
      if (rst) begin
         op_r     <= 5'b00000;
         acc_r    <= ALL_ZERO;
         x_r      <= ALL_ZERO;
         y_r      <= ALL_ZERO;
         cnt_r    <= {SHAMT_W{1'b0}};
         result_r <= ALL_ZERO;
         zero_r   <= 1'b0;
         dz_r     <= 1'b0;
         ill_r    <= 1'b0;
      end else begin
         case (state_r)
            S_IDLE: begin
               if (accept_s) begin
                  op_r  <= bus.opcode;
                  acc_r <= ALL_ZERO;
                  x_r   <= bus.op_a;
                  y_r   <= bus.op_b;
                  cnt_r <= {SHAMT_W{1'b0}};
                  if (!start_iter_s) begin
                     result_r <= single_res_s;
                     zero_r   <= (single_res_s == ALL_ZERO);
                     dz_r     <= dz_in_s;
                     ill_r    <= !is_legal(bus.opcode);
                  end
               end
            end
            S_BUSY: begin
               acc_r <= step_acc_s;
               x_r   <= step_x_s;
               y_r   <= step_y_s;
               cnt_r <= cnt_r + {{(SHAMT_W-1){1'b0}}, 1'b1};
               if (last_iter_s) begin
                  result_r <= iter_res_s;
                  zero_r   <= (iter_res_s == ALL_ZERO);
                  dz_r     <= 1'b0;
                  ill_r    <= 1'b0;
               end
            end
            default: begin
               result_r <= result_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_seq.sv
// Directed-vector bench for alu_seq: stimulus pushes expected responses into a queue,
// an independent monitor pops and compares them at every output handshake.
module tb_alu_seq;

   localparam int W = 32;

   localparam logic [4:0] ADD = 5'b00001, SUB = 5'b00010, MUL = 5'b00011, DIV = 5'b00100;
   localparam logic [4:0] MOD = 5'b00101, MAX = 5'b00110, MIN = 5'b00111, NOT = 5'b01000;
   localparam logic [4:0] NAND = 5'b01001, XNOR = 5'b01010, SLL = 5'b01011, SRL = 5'b01100;
   localparam logic [4:0] SRA = 5'b01101, ILL0 = 5'b00000, ILL31 = 5'b11111;

   typedef struct {
      string       name;
      logic [31:0] res;
      logic        z;
      logic        dz;
      logic        ill;
      int          lat;
      int          acc_cyc;
   } exp_t;

   logic clk;
   logic rst;
   int   cyc;
   int   checks;
   int   failures;
   int   first_cyc;
   logic ov_prev;
   exp_t sb[$];

   alu_seq_if #(.WIDTH(W), .SHAMT_W(5)) bus();

   alu_seq #(.WIDTH(W), .SHAMT_W(5)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      checks++;
      if (act !== expv) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic set_out_ready(input logic v);
      @(posedge clk);
      #1 bus.out_ready = v;
   endtask

   // Waits for in_ready, presents one request for exactly one accept edge, then scrambles inputs.
   task automatic issue(input string name, input logic [4:0] op, input logic [31:0] a,
                        input logic [31:0] b, input logic [4:0] sh, input logic [31:0] er,
                        input logic ez, input logic edz, input logic eill, input int elat,
                        input bit push);
      int   waited;
      exp_t e;
      waited = 0;
      @(negedge clk);
      while (!bus.in_ready && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      if (!bus.in_ready) begin
         checks++;
         failures++;
         $display("FAIL %s_accept_timeout: in_ready stayed %b, required 1", name, bus.in_ready);
      end else begin
         bus.in_valid = 1'b1;
         bus.opcode   = op;
         bus.op_a     = a;
         bus.op_b     = b;
         bus.shamt    = sh;
         if (push) begin
            e.name = name; e.res = er; e.z = ez; e.dz = edz; e.ill = eill;
            e.lat = elat; e.acc_cyc = cyc;
            sb.push_back(e);
         end
         @(negedge clk);
         bus.in_valid = 1'b0;
         bus.opcode   = 5'b11111;
         bus.op_a     = $urandom;
         bus.op_b     = $urandom;
         bus.shamt    = 5'($urandom_range(0, 31));
      end
   endtask

   // Monitor: compares result, flags and latency whenever a result is handed off.
   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (bus.out_valid && !ov_prev) first_cyc = cyc;
         if (bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
               checks++;
               failures++;
               $display("FAIL unexpected_output: got result %h with empty scoreboard", bus.result);
            end else begin
               e = sb.pop_front();
               chk({e.name, "_result"}, bus.result, e.res);
               chk({e.name, "_flags"}, {29'd0, bus.flag_zero, bus.flag_dz, bus.flag_ill},
                   {29'd0, e.z, e.dz, e.ill});
               chk({e.name, "_latency"}, 32'(first_cyc - e.acc_cyc), 32'(e.lat));
            end
         end
      end
      ov_prev = bus.out_valid;
   end

   initial begin
      int busy_hi;
      int bp_bad_res;
      int bp_bad_rdy;
      int waited;
      cyc = 0; checks = 0; failures = 0; first_cyc = 0; ov_prev = 1'b0;
      rst = 1'b1;
      bus.in_valid = 1'b0; bus.opcode = 5'b00000; bus.op_a = 32'd0; bus.op_b = 32'd0;
      bus.shamt = 5'd0; bus.out_ready = 1'b1;
      repeat (3) @(negedge clk);
      chk("reset_state", {26'd0, bus.in_ready, bus.out_valid, bus.result == 32'd0,
          bus.flag_zero, bus.flag_dz, bus.flag_ill}, {26'd0, 6'b101000});
      rst = 1'b0;

      issue("add_wrap", ADD, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 1, 1'b1);
      chk("add_in_ready_done", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("add_in_ready_after", {31'd0, bus.in_ready}, 32'd1);

      issue("sub", SUB, 32'd5, 32'd7, 5'd0, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1, 1'b1);

      issue("mul", MUL, 32'h0001_2345, 32'h0000_0100, 5'd0, 32'h0123_4500, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      busy_hi = 0;
      for (int i = 0; i < 32; i++) begin
         if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) busy_hi++;
         @(negedge clk);
      end
      chk("mul_busy_in_ready", 32'(busy_hi), 32'd0);

      issue("mul_ones", MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0, 32'd1, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      issue("div", DIV, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      issue("mod", MOD, 32'd100, 32'd7, 5'd0, 32'd2, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      issue("div_zero", DIV, 32'd5, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b0, 1, 1'b1);
      issue("mod_zero", MOD, 32'd5, 32'd0, 5'd0, 32'd5, 1'b0, 1'b1, 1'b0, 1, 1'b1);
      issue("div_zero_quot", DIV, 32'd0, 32'd3, 5'd0, 32'd0, 1'b1, 1'b0, 1'b0, 33, 1'b1);
      issue("div_by_one", DIV, 32'hFFFF_FFFF, 32'd1, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      issue("mod_big", MOD, 32'hFFFF_FFFF, 32'h10, 5'd0, 32'hF, 1'b0, 1'b0, 1'b0, 33, 1'b1);
      issue("sra", SRA, 32'h8000_0000, 32'd0, 5'd4, 32'hF800_0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("srl", SRL, 32'h8000_0000, 32'd0, 5'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("sll", SLL, 32'h0000_0001, 32'd0, 5'd31, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("ill_31", ILL31, 32'h1234_5678, 32'd9, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 1, 1'b1);
      issue("ill_0", ILL0, 32'h1234_5678, 32'd9, 5'd3, 32'd0, 1'b1, 1'b0, 1'b1, 1, 1'b1);
      issue("not", NOT, 32'd0, 32'd0, 5'd0, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("nand", NAND, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'h0FFF_0FFF, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("xnor", XNOR, 32'hF0F0_F0F0, 32'hFF00_FF00, 5'd0, 32'hF00F_F00F, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      issue("min", MIN, 32'd3, 32'd9, 5'd0, 32'd3, 1'b0, 1'b0, 1'b0, 1, 1'b1);

      set_out_ready(1'b0);
      issue("max_bp", MAX, 32'd3, 32'd9, 5'd0, 32'd9, 1'b0, 1'b0, 1'b0, 1, 1'b1);
      bp_bad_res = 0;
      bp_bad_rdy = 0;
      for (int i = 0; i < 10; i++) begin
         if (bus.result !== 32'd9 || bus.out_valid !== 1'b1) bp_bad_res++;
         if (bus.in_ready !== 1'b0) bp_bad_rdy++;
         @(negedge clk);
      end
      chk("bp_result_held", 32'(bp_bad_res), 32'd0);
      chk("bp_in_ready_low", 32'(bp_bad_rdy), 32'd0);
      set_out_ready(1'b1);

      issue("rst_div", DIV, 32'd100, 32'd7, 5'd0, 32'd14, 1'b0, 1'b0, 1'b0, 33, 1'b0);
      repeat (8) @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_mid_op", {29'd0, bus.out_valid, bus.in_ready, bus.result == 32'd0}, {29'd0, 3'b011});
      issue("add_after_rst", ADD, 32'd2, 32'd3, 5'd0, 32'd5, 1'b0, 1'b0, 1'b0, 1, 1'b1);

      waited = 0;
      while (sb.size() != 0 && waited < 200) begin
         @(negedge clk);
         waited++;
      end
      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(sb.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, handshaked successor to the single-cycle registered ALU.
- Executes one operation at a time under valid/ready flow control on both sides.
- Single-cycle ops complete in 1 cycle; MUL/DIV/MOD run iteratively over WIDTH cycles.
- Sits between the decode/issue stage and writeback; also reports status flags.

Parameters:
- WIDTH, 32, operand/result width in bits (>=4).
- SHAMT_W, 5, shift-amount width; must equal clog2(WIDTH).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  operation request valid.
- in_ready  output  1  block can accept a request.
- opcode  input  5  operation select (encoding below).
- op_a  input  WIDTH  operand A.
- op_b  input  WIDTH  operand B.
- shamt  input  SHAMT_W  shift amount.
- out_valid  output  1  result/flags valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  operation result.
- flag_zero  output  1  result == 0.
- flag_dz  output  1  DIV/MOD with op_b == 0.
- flag_ill  output  1  illegal opcode.

Behaviour:
- Reset: state=IDLE, in_ready=1, out_valid=0, result=0, all flags=0. Reset mid-operation abandons the operation with no output.
- Accept: a request is accepted on a rising edge with in_valid && in_ready. Opcode, operands and shamt are latched; later input changes are ignored.
- in_ready is 1 only in IDLE. No new request is accepted while BUSY or DONE.
- States:
  - IDLE -> DONE for single-cycle ops (out_valid=1 on the edge after acceptance).
  - IDLE -> BUSY for MUL/DIV/MOD.
  - BUSY -> DONE after exactly WIDTH iteration cycles; out_valid=1 on edge WIDTH+1 after acceptance.
  - DONE -> IDLE on the edge where out_ready=1. result and flags are held stable while out_valid && !out_ready.
- Opcodes (all unsigned; results truncated to WIDTH):
  - 00001 ADD, a+b mod 2^WIDTH.
  - 00010 SUB, a-b mod 2^WIDTH.
  - 00011 MUL, low WIDTH bits of a*b; shift-add, one bit per cycle.
  - 00100 DIV, floor(a/b); restoring, one quotient bit per cycle.
  - 00101 MOD, a mod b; same datapath as DIV.
  - 00110 MAX, 00111 MIN (unsigned compare).
  - 01000 NOT a, 01001 NAND, 01010 XNOR.
  - 01011 SLL a by shamt, 01100 SRL a by shamt (zero fill), 01101 SRA a by shamt (sign fill).
- Divide by zero (DIV/MOD, op_b=0): no iteration; goes IDLE -> DONE with 1-cycle latency and flag_dz=1. DIV result = all ones; MOD result = op_a.
- Illegal opcodes (00000, 01110-11111): 1-cycle latency, result=0, flag_ill=1, flag_zero=1.
- flag_zero is computed from the final result for every op. flag_dz and flag_ill are 0 except in the cases above.
- No bypass from out_ready to in_ready: at most one op in flight; the minimum interval between accepts is 2 cycles.

Test Plan:
- ADD a=0xFFFFFFFF, b=1, out_ready=1 -> out_valid one cycle after accept, result=0, flag_zero=1. in_ready high again the following cycle.
- MUL a=0x00012345, b=0x00000100 -> out_valid exactly 33 cycles after accept, result=0x01234500. in_ready=0 throughout BUSY.
- DIV a=100, b=7 -> result=14. MOD with the same operands -> result=2. Both 33-cycle latency, flag_dz=0.
- DIV a=5, b=0 -> 1-cycle latency, result=0xFFFFFFFF, flag_dz=1. MOD a=5, b=0 -> result=5, flag_dz=1.
- SRA a=0x80000000, shamt=4 -> 0xF8000000. SRL same -> 0x08000000. Opcode 11111 -> result=0, flag_ill=1.
- Backpressure and reset: hold out_ready=0 for 10 cycles after a MAX(3,9) -> result stays 9, in_ready=0 all 10 cycles. Separately, assert rst during cycle 10 of a DIV -> next cycle out_valid=0, in_ready=1, result=0.
